uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of entries; the block SHALL support only powers of two from 2 to 256.
REQ-002 Parameter TIMEOUT_CYCLES, default 16000, idle cycles before the character timeout fires.
REQ-003 wb_clk_i  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 wb_rst_i  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  one-cycle strobe from the UART receiver: byte complete.
REQ-006 in_data  in  8  received byte, qualified by in_valid.
REQ-007 in_frame_err  in  1  stop-bit error for this byte, qualified by in_valid.
REQ-008 pop  in  1  read strobe from the CSR block; consumes the head entry.
REQ-009 threshold  in  $clog2(DEPTH)+1  fill level that raises irq; 0 disables the level interrupt.
REQ-010 overrun_clr  in  1  clears the sticky overrun flag.
REQ-011 out_data  out  8  head byte, valid when out_valid=1.
REQ-012 out_frame_err  out  1  frame-error bit stored with the head byte.
REQ-013 out_valid  out  1  FIFO not empty.
REQ-014 full  out  1  count==DEPTH.
REQ-015 count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overrun  out  1  sticky flag: a byte was dropped.
REQ-017 timeout  out  1  character-timeout flag.
REQ-018 irq  out  1  level interrupt toward user_irq[0].

Function
REQ-019 Storage SHALL hold 9 bits per entry: {frame_err, data}; write and read pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-020 Push condition: in_valid && (!full || pop).
  - Accepted entry written at the write pointer; write pointer += 1.
REQ-021 Pop condition: pop && out_valid.
  - Read pointer += 1.
  - pop while empty SHALL be ignored with no state change.
REQ-022 Occupancy update:
  - count += 1 on push only.
  - count -= 1 on pop only.
  - count unchanged on simultaneous push and pop.
REQ-023 Simultaneous push and pop when empty: the pop SHALL be ignored and the push accepted, so count becomes 1.
REQ-024 Simultaneous push and pop when full: both SHALL be accepted; count stays DEPTH and overrun is not set.
REQ-025 Overrun: in_valid && full && !pop SHALL drop the byte and set overrun on the same edge; FIFO contents are unchanged.
REQ-026 overrun SHALL hold until an overrun_clr edge.
  - If overrun_clr and a new drop occur in the same cycle, overrun SHALL remain 1.
REQ-027 Read path is first-word-fall-through:
  - out_data, out_frame_err and out_valid SHALL reflect the head entry one cycle after the pushing edge.
  - There is no read latency after pop; the next head appears the cycle after the pop edge.
REQ-028 out_data SHALL be 8'h00 whenever out_valid=0.
REQ-029 irq SHALL be (threshold!=0 && count>=threshold) OR timeout, computed from registered state, with no glitch path from inputs.

Reset
REQ-030 With wb_rst_i=1 at an edge, the block SHALL clear:
  - both pointers and count;
  - overrun and timeout;
  - the timeout counter.
REQ-031 Reset values: out_valid=0, full=0, count=0, out_data=8'h00, out_frame_err=0, irq=0.
REQ-032 Reset SHALL override any push or pop in the same cycle.
REQ-033 Storage contents need not be cleared by reset.

Configuration
REQ-034 Macro UART_RX_FIFO_TIMEOUT_EN controls the character timeout.
REQ-035 With UART_RX_FIFO_TIMEOUT_EN defined, the timeout counter SHALL behave as follows:
  - Counts wb_clk_i cycles while out_valid=1 with no push and no pop.
  - Resets to 0 on any push or pop, or when the FIFO is empty.
  - On reaching TIMEOUT_CYCLES, sets timeout.
  - timeout clears on the next pop or when the FIFO becomes empty.
REQ-036 With UART_RX_FIFO_TIMEOUT_EN undefined:
  - No counter logic SHALL be synthesised.
  - timeout SHALL be tied to 0.
  - irq SHALL depend on the level term only.

Verification
REQ-037 Push 8'hA5, 8'h3C, 8'hFF, then three pops -> out_data reads A5, 3C, FF in order; count goes 3,2,1,0; out_valid drops after the third pop.
REQ-038 Push 17 bytes with DEPTH=16 and no pop -> full=1 after byte 16; byte 17 is dropped; overrun=1; count=16; an overrun_clr pulse then clears overrun.
REQ-039 FIFO full, then push 8'h77 and pop in the same cycle -> count stays 16, overrun=0; 8'h77 is read out as the 16th byte after the remaining 15.
REQ-040 threshold=4, push 4 bytes -> irq rises the cycle after the 4th push edge; one pop -> irq falls; threshold=0 with 16 bytes -> irq=0.
REQ-041 Push 8'h55 with in_frame_err=1 -> out_frame_err=1 with head 8'h55; assert wb_rst_i mid-stream with 5 entries -> count=0, out_valid=0, irq=0 next cycle.
REQ-042 Timeout check, UART_RX_FIFO_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, one byte pushed then idle:
  - timeout and irq rise exactly 100 cycles after the push edge.
  - A pop clears timeout.
  - With the macro undefined, timeout stays 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO of {frame_err, data} entries with sticky
// overrun, level irq and an optional character timeout enabled by `define UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16000
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     in_frame_err,
  input  logic                     pop,
  input  logic [$clog2(DEPTH):0]   threshold,
  input  logic                     overrun_clr,
  output logic [7:0]               out_data,
  output logic                     out_frame_err,
  output logic                     out_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     timeout,
  output logic                     irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_rx_fifo: DEPTH must be a power of two in 2..256 and TIMEOUT_CYCLES >= 1");
  end

  logic [8:0]    mem_q [DEPTH];
  logic [8:0]    head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          irq_q, irq_d;
  logic          timeout_d;
  logic          is_full, is_empty, push, do_pop, drop;

  always_comb begin
    is_full   = (count_q == CW'(DEPTH));
    is_empty  = (count_q == '0);
    do_pop    = pop && !is_empty;
    push      = in_valid && (!is_full || pop);
    drop      = in_valid && is_full && !pop;
    wr_ptr_d  = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    case ({push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear wins, so no overrun event is lost.
    overrun_d = drop || (overrun_q && !overrun_clr);
    irq_d     = ((threshold != '0) && (count_d >= threshold)) || timeout_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && push) begin
      mem_q[wr_ptr_q] <= {in_frame_err, in_data};
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q;

  // Counter saturates at TIMEOUT_CYCLES; timeout is sticky until a pop or the FIFO drains.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (push || do_pop || is_empty) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TW'(TIMEOUT_CYCLES)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    timeout_d = timeout_q;
    if (do_pop || count_d == '0) begin
      timeout_d = 1'b0;
    end else if (tmo_cnt_d == TW'(TIMEOUT_CYCLES)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout_d = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign head          = mem_q[rd_ptr_q];
  assign out_valid     = !is_empty;
  assign out_data      = is_empty ? 8'h00 : head[7:0];
  assign out_frame_err = !is_empty && head[8];
  assign full          = is_full;
  assign count         = count_q;
  assign overrun       = overrun_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed table, corner sequences and a randomized run
// against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 100;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_frame_err = 1'b0;
  logic          pop = 1'b0;
  logic [CW-1:0] threshold = '0;
  logic          overrun_clr = 1'b0;
  logic [7:0]    out_data;
  logic          out_frame_err, out_valid, full, overrun, timeout, irq;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_frame_err  (in_frame_err),
    .pop           (pop),
    .threshold     (threshold),
    .overrun_clr   (overrun_clr),
    .out_data      (out_data),
    .out_frame_err (out_frame_err),
    .out_valid     (out_valid),
    .full          (full),
    .count         (count),
    .overrun       (overrun),
    .timeout       (timeout),
    .irq           (irq)
  );

  logic [8:0] mq[$];
  bit m_ovr, m_tmo, m_irq;
  int m_last, edge_n;
  int n_cmp, n_bad;

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         fe;
    bit         p;
    int         e_count;
    bit         e_valid;
    logic [7:0] e_data;
    bit         e_fe;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic check_model();
    chk("count", int'(count), mq.size());
    chk("out_valid", int'(out_valid), int'(mq.size() != 0));
    chk("out_data", int'(out_data), (mq.size() != 0) ? int'(mq[0][7:0]) : 0);
    chk("out_frame_err", int'(out_frame_err), (mq.size() != 0) ? int'(mq[0][8]) : 0);
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("overrun", int'(overrun), int'(m_ovr));
    chk("timeout", int'(timeout), int'(m_tmo));
    chk("irq", int'(irq), int'(m_irq));
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] d, input bit fe,
                      input bit p, input bit clr);
    bit m_full, m_pop, m_push, m_drop;
    rst = r; in_valid = v; in_data = d; in_frame_err = fe; pop = p; overrun_clr = clr;
    @(posedge clk);
    edge_n++;
    if (r) begin
      mq.delete();
      m_ovr  = 1'b0;
      m_tmo  = 1'b0;
      m_last = edge_n;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_pop  = p && (mq.size() != 0);
      m_push = v && (!m_full || p);
      m_drop = v && m_full && !p;
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back({fe, d});
      m_ovr = m_drop || (m_ovr && !clr);
      if (m_push || m_pop) m_last = edge_n;
      if (m_pop || mq.size() == 0) m_tmo = 1'b0;
      else if (TMO_EN && (edge_n - m_last) >= int'(TMO)) m_tmo = 1'b1;
    end
    m_irq = ((threshold != 0) && (mq.size() >= int'(threshold))) || m_tmo;
    #1;
    check_model();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_frame_err = 1'b0; pop = 1'b0; overrun_clr = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; edge_n = 0; m_last = 0;

    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0};
    tbl[1]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 2, 1'b1, 8'hA5, 1'b0};
    tbl[2]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3, 1'b1, 8'hA5, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b1, 8'h3C, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b1, 8'hFF, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 1, 1'b1, 8'h5A, 1'b0};
    tbl[8]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1, 1'b1, 8'h11, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{1'b1, 8'h55, 1'b1, 1'b0, 1, 1'b1, 8'h55, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};

    // Reset state
    step(1, 0, 8'h00, 0, 0, 0);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_irq", int'(irq), 0);

    for (int i = 0; i < 12; i++) begin
      step(0, tbl[i].v, tbl[i].d, tbl[i].fe, tbl[i].p, 0);
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_count);
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_data", i), int'(out_data), int'(tbl[i].e_data));
      chk($sformatf("tbl%0d_fe", i), int'(out_frame_err), int'(tbl[i].e_fe));
    end

    // Fill to full, drop the 17th byte, clear overrun, clear racing a drop
    step(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'(i + 1), 0, 0, 0);
      if (i == 14) chk("fill_not_full", int'(full), 0);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 16);
    step(0, 1, 8'hEE, 0, 0, 0);
    chk("drop_overrun", int'(overrun), 1);
    chk("drop_count", int'(count), 16);
    chk("drop_head", int'(out_data), 8'h01);
    step(0, 0, 8'h00, 0, 0, 1);
    chk("ovr_clr", int'(overrun), 0);
    step(0, 1, 8'hEE, 0, 0, 1);
    chk("ovr_clr_race", int'(overrun), 1);
    step(0, 0, 8'h00, 0, 0, 1);
    chk("ovr_clr2", int'(overrun), 0);

    // Push+pop while full
    step(0, 1, 8'h77, 0, 1, 0);
    chk("fullpp_count", int'(count), 16);
    chk("fullpp_overrun", int'(overrun), 0);
    for (int i = 0; i < 15; i++) step(0, 0, 8'h00, 0, 1, 0);
    chk("fullpp_last", int'(out_data), 8'h77);
    chk("fullpp_last_cnt", int'(count), 1);
    step(0, 0, 8'h00, 0, 1, 0);
    chk("fullpp_empty", int'(out_valid), 0);

    // Level interrupt
    step(1, 0, 8'h00, 0, 0, 0);
    threshold = CW'(4);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'(8'h20 + i), 0, 0, 0);
      if (i == 2) chk("irq_below", int'(irq), 0);
    end
    chk("irq_at_thr", int'(irq), 1);
    step(0, 0, 8'h00, 0, 1, 0);
    chk("irq_after_pop", int'(irq), 0);
    threshold = '0;
    step(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 0, 0);
    chk("irq_thr0", int'(irq), 0);

    // Reset mid-stream overrides push and pop
    step(1, 0, 8'h00, 0, 0, 0);
    threshold = CW'(2);
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h40 + i), 0, 0, 0);
    chk("mid_irq_pre", int'(irq), 1);
    step(1, 1, 8'h99, 0, 1, 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_irq", int'(irq), 0);
    threshold = '0;

    // Character timeout
    step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h42, 0, 0, 0);
    for (int i = 1; i <= 100; i++) begin
      step(0, 0, 8'h00, 0, 0, 0);
      if (i == 99) chk("tmo_early", int'(timeout), 0);
      if (i == 100) begin
        chk("tmo_fire", int'(timeout), int'(TMO_EN));
        chk("tmo_irq", int'(irq), int'(TMO_EN));
      end
    end
    step(0, 0, 8'h00, 0, 1, 0);
    chk("tmo_pop_clr", int'(timeout), 0);

    // Randomized run against the model
    for (int blk = 0; blk < 12; blk++) begin
      int mode;
      mode = blk % 3;
      threshold = CW'($urandom_range(0, DEPTH));
      for (int c = 0; c < 250; c++) begin
        bit v, p, clr, r;
        case (mode)
          0: begin v = ($urandom % 4) != 0; p = ($urandom % 3) == 0; end
          1: begin v = ($urandom % 3) == 0; p = ($urandom % 4) != 0; end
          default: begin v = ($urandom % 120) == 0; p = ($urandom % 150) == 0; end
        endcase
        clr = ($urandom % 20) == 0;
        r   = ($urandom % 500) == 0;
        step(r, v, 8'($urandom), 1'($urandom), p, clr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
